// File: rtl/frame_counter_axi_slave_if.sv
// AXI4-Lite bus bundle for the frame counter peripheral.
// The master modport is the interconnect side and the slave modport is the register file side.
interface frame_counter_axi_slave_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                        S_AXI_AWPROT;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                        S_AXI_ARPROT;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, input S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, input S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
    );
endinterface

// File: rtl/frame_counter_axi_slave.sv
// AXI4-Lite register file for the frame counter: counts rising edges of frame_sync and raises a
// sticky compare interrupt. Single-beat reads/writes, one of each outstanding.
module frame_counter_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESETN,
    frame_counter_axi_slave_if.slave    s_axi,
    input  logic                        frame_sync,
    output logic                        irq
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_CNT  = 2'd1;
    localparam logic [1:0] REG_CMP  = 2'd2;
    localparam logic [1:0] REG_SCR  = 2'd3;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int i = 0; i < SW; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic          aw_latched_r, w_latched_r;
    logic [AW-1:0] awaddr_r;
    logic [DW-1:0] wdata_r;
    logic [SW-1:0] wstrb_r;
    logic          awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
    logic [DW-1:0] rdata_r;
    logic          en_r, irq_en_r, irq_stat_r, fs_q_r, irq_r;
    logic [DW-1:0] frame_cnt_r, compare_r, scratch_r;

    logic          aw_hs_s, w_hs_s, ar_hs_s, wr_fire_s;
    logic [AW-1:0] wr_addr_s;
    logic [DW-1:0] wr_data_s;
    logic [SW-1:0] wr_strb_s;
    logic [1:0]    wr_sel_s;
    logic          aw_latched_nxt_s, w_latched_nxt_s, bvalid_nxt_s, rvalid_nxt_s;
    logic          edge_s, inc_s, hit_s, clr_s, w1c_s, cnt_wr_s;
    logic          en_nxt_s, irq_en_nxt_s, irq_stat_nxt_s;
    logic [DW-1:0] cnt_inc_s, cnt_wr_val_s, frame_cnt_nxt_s, compare_nxt_s, scratch_nxt_s;
    logic [DW-1:0] rd_mux_s;
    logic          unused_bits_s;

    assign aw_hs_s   = s_axi.S_AXI_AWVALID & awready_r;
    assign w_hs_s    = s_axi.S_AXI_WVALID & wready_r;
    assign ar_hs_s   = s_axi.S_AXI_ARVALID & arready_r;
    // The write lands in the cycle the second half (address or data) arrives, so that B follows one cycle later.
    assign wr_fire_s = (aw_latched_r | aw_hs_s) & (w_latched_r | w_hs_s) & ~bvalid_r;
    assign wr_addr_s = aw_latched_r ? awaddr_r : s_axi.S_AXI_AWADDR;
    assign wr_data_s = w_latched_r ? wdata_r : s_axi.S_AXI_WDATA;
    assign wr_strb_s = w_latched_r ? wstrb_r : s_axi.S_AXI_WSTRB;
    assign wr_sel_s  = wr_addr_s[3:2];

    assign aw_latched_nxt_s = wr_fire_s ? 1'b0 : (aw_latched_r | aw_hs_s);
    assign w_latched_nxt_s  = wr_fire_s ? 1'b0 : (w_latched_r | w_hs_s);
    assign bvalid_nxt_s     = wr_fire_s | (bvalid_r & ~s_axi.S_AXI_BREADY);
    assign rvalid_nxt_s     = ar_hs_s | (rvalid_r & ~s_axi.S_AXI_RREADY);

    assign edge_s    = frame_sync & ~fs_q_r;
    assign inc_s     = en_r & edge_s;
    assign cnt_inc_s = frame_cnt_r + DW'(1);

    // Register write decode: field updates and the CLR / W1C strobes.
    always_comb begin
        en_nxt_s      = en_r;
        irq_en_nxt_s  = irq_en_r;
        clr_s         = 1'b0;
        w1c_s         = 1'b0;
        cnt_wr_s      = 1'b0;
        compare_nxt_s = compare_r;
        scratch_nxt_s = scratch_r;
        cnt_wr_val_s  = merge_bytes(frame_cnt_r, wr_data_s, wr_strb_s);
        if (wr_fire_s) begin
            case (wr_sel_s)
                REG_CTRL: begin
                    if (wr_strb_s[0]) begin
                        en_nxt_s     = wr_data_s[0];
                        clr_s        = wr_data_s[1];
                        irq_en_nxt_s = wr_data_s[2];
                    end else begin
                        clr_s = 1'b0;
                    end
                    if (wr_strb_s[1]) begin
                        w1c_s = wr_data_s[8];
                    end else begin
                        w1c_s = 1'b0;
                    end
                end
                REG_CNT: cnt_wr_s      = 1'b1;
                REG_CMP: compare_nxt_s = merge_bytes(compare_r, wr_data_s, wr_strb_s);
                REG_SCR: scratch_nxt_s = merge_bytes(scratch_r, wr_data_s, wr_strb_s);
                default: cnt_wr_s      = 1'b0;
            endcase
        end else begin
            cnt_wr_s = 1'b0;
        end
    end

    // Counter priority (clear, bus write, increment) and the sticky compare flag.
    always_comb begin
        frame_cnt_nxt_s = frame_cnt_r;
        hit_s           = 1'b0;
        if (clr_s) begin
            frame_cnt_nxt_s = '0;
        end else if (cnt_wr_s) begin
            frame_cnt_nxt_s = cnt_wr_val_s;
        end else if (inc_s) begin
            frame_cnt_nxt_s = cnt_inc_s;
            hit_s           = (cnt_inc_s == compare_r);
        end else begin
            frame_cnt_nxt_s = frame_cnt_r;
        end
        if (hit_s) begin
            irq_stat_nxt_s = 1'b1;
        end else if (w1c_s) begin
            irq_stat_nxt_s = 1'b0;
        end else begin
            irq_stat_nxt_s = irq_stat_r;
        end
    end

    // Read data selection, sampled into rdata_r on the AR handshake.
    always_comb begin
        rd_mux_s = '0;
        case (s_axi.S_AXI_ARADDR[3:2])
            REG_CTRL: rd_mux_s = {{(DW-9){1'b0}}, irq_stat_r, 5'b0_0000, irq_en_r, 1'b0, en_r};
            REG_CNT:  rd_mux_s = frame_cnt_r;
            REG_CMP:  rd_mux_s = compare_r;
            REG_SCR:  rd_mux_s = scratch_r;
            default:  rd_mux_s = '0;
        endcase
    end

    // All sequential state: bus handshakes, registers, edge detector and interrupt output.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_latched_r <= 1'b0;
            w_latched_r  <= 1'b0;
            awaddr_r     <= '0;
            wdata_r      <= '0;
            wstrb_r      <= '0;
            awready_r    <= 1'b0;
            wready_r     <= 1'b0;
            bvalid_r     <= 1'b0;
            arready_r    <= 1'b0;
            rvalid_r     <= 1'b0;
            rdata_r      <= '0;
            en_r         <= 1'b0;
            irq_en_r     <= 1'b0;
            irq_stat_r   <= 1'b0;
            fs_q_r       <= 1'b0;
            irq_r        <= 1'b0;
            frame_cnt_r  <= '0;
            compare_r    <= '0;
            scratch_r    <= '0;
        end else begin
            aw_latched_r <= aw_latched_nxt_s;
            w_latched_r  <= w_latched_nxt_s;
            if (aw_hs_s) begin
                awaddr_r <= s_axi.S_AXI_AWADDR;
            end
            if (w_hs_s) begin
                wdata_r <= s_axi.S_AXI_WDATA;
                wstrb_r <= s_axi.S_AXI_WSTRB;
            end
            awready_r    <= ~aw_latched_nxt_s & ~bvalid_nxt_s;
            wready_r     <= ~w_latched_nxt_s & ~bvalid_nxt_s;
            bvalid_r     <= bvalid_nxt_s;
            arready_r    <= ~rvalid_nxt_s;
            rvalid_r     <= rvalid_nxt_s;
            if (ar_hs_s) begin
                rdata_r <= rd_mux_s;
            end
            en_r         <= en_nxt_s;
            irq_en_r     <= irq_en_nxt_s;
            irq_stat_r   <= irq_stat_nxt_s;
            fs_q_r       <= frame_sync;
            irq_r        <= irq_stat_nxt_s & irq_en_nxt_s;
            frame_cnt_r  <= frame_cnt_nxt_s;
            compare_r    <= compare_nxt_s;
            scratch_r    <= scratch_nxt_s;
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_r;
    assign s_axi.S_AXI_WREADY  = wready_r;
    assign s_axi.S_AXI_BVALID  = bvalid_r;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_ARREADY = arready_r;
    assign s_axi.S_AXI_RVALID  = rvalid_r;
    assign s_axi.S_AXI_RDATA   = rdata_r;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign irq                 = irq_r;

    assign unused_bits_s = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                             wr_addr_s[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule
